// File: rtl/spi_txn_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Byte engine command codes and transaction FSM states.
package spi_txn_pkg;

   localparam logic [7:0] CMD_WRITE       = 8'h0A;
   localparam logic [7:0] CMD_READ        = 8'h0B;
   localparam int         DEFAULT_NCS_GAP = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_HOLD,
      ST_GAP
   } state_t;

   function automatic logic len_bad(input logic [2:0] len, input int max_bytes);
      return (len == 3'd0) || (int'(len) > max_bytes);
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-served pointer.
// The pointer updates only on the strobe, so it tracks the current owner after a latch.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt,
   output logic       last
);

   always_comb begin
      gnt = req;
      if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
   end

   // Reset as if requester 1 was served last, so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst)                last <= 1'b1;
      else if (upd && |gnt)   last <= gnt[1];
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Arbitrates two register-access requesters onto one SPI byte engine, framing
// each transaction with chip select and assembling read data into one word.
module spi_txn_arbiter
   import spi_txn_pkg::*;
#(
   parameter int NCS_GAP   = DEFAULT_NCS_GAP,
   parameter int MAX_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        rw0,
   input  logic        rw1,
   input  logic [7:0]  addr0,
   input  logic [7:0]  addr1,
   input  logic [2:0]  len0,
   input  logic [2:0]  len1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err,
   output logic [31:0] rdata,
   output logic        byte_start,
   output logic [7:0]  byte_tx,
   input  logic        byte_done,
   input  logic [7:0]  byte_rx,
   output logic        ncs_o,
   output logic        clk_enable
);

   localparam int GW = $clog2(NCS_GAP);

   state_t         state;
   logic [1:0]     arb_gnt;
   logic           last;
   logic           latch;
   logic           rw_q;
   logic [7:0]     addr_q;
   logic [2:0]     len_q;
   logic [31:0]    wdata_q;
   logic           bad_q;
   logic [2:0]     idx;
   logic [GW-1:0]  gap_cnt;
   logic           sel_rw;
   logic [7:0]     sel_addr;
   logic [2:0]     sel_len;
   logic [31:0]    sel_wdata;

   assign latch = (state == ST_IDLE) && (req0 || req1);

   rr_arbiter2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  ({req1, req0}),
      .upd  (latch),
      .gnt  (arb_gnt),
      .last (last)
   );

   always_comb begin
      sel_rw    = arb_gnt[1] ? rw1    : rw0;
      sel_addr  = arb_gnt[1] ? addr1  : addr0;
      sel_len   = arb_gnt[1] ? len1   : len0;
      sel_wdata = arb_gnt[1] ? wdata1 : wdata0;
   end

   // After the latch, 'last' names the current owner for the rest of the transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
         byte_start <= 1'b0;
         byte_tx    <= '0;
         ncs_o      <= 1'b1;
         clk_enable <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         wdata_q    <= '0;
         bad_q      <= 1'b0;
         idx        <= '0;
         gap_cnt    <= '0;
      end else begin
         byte_start <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err        <= 1'b0;
         case (state)
            ST_IDLE: if (latch) begin
               rw_q    <= sel_rw;
               addr_q  <= sel_addr;
               len_q   <= sel_len;
               wdata_q <= sel_wdata;
               bad_q   <= len_bad(sel_len, MAX_BYTES);
               rdata   <= '0;
               gnt0    <= arb_gnt[0];
               gnt1    <= arb_gnt[1];
               if (!len_bad(sel_len, MAX_BYTES)) begin
                  ncs_o      <= 1'b0;
                  clk_enable <= 1'b1;
               end
               state <= ST_SETUP;
            end
            // An illegal length completes through a one-cycle GAP so the
            // requester has dropped req before IDLE looks again.
            ST_SETUP: if (bad_q) begin
               done0   <= !last;
               done1   <= last;
               err     <= 1'b1;
               gap_cnt <= '0;
               state   <= ST_GAP;
            end else begin
               byte_start <= 1'b1;
               byte_tx    <= rw_q ? CMD_WRITE : CMD_READ;
               state      <= ST_CMD;
            end
            ST_CMD: if (byte_done) begin
               byte_start <= 1'b1;
               byte_tx    <= addr_q;
               state      <= ST_ADDR;
            end
            ST_ADDR: if (byte_done) begin
               byte_start <= 1'b1;
               byte_tx    <= rw_q ? byte_of(wdata_q, 2'd0) : 8'h00;
               idx        <= '0;
               state      <= ST_DATA;
            end
            ST_DATA: if (byte_done) begin
               if (!rw_q) rdata[{idx[1:0], 3'b000} +: 8] <= byte_rx;
               if (idx == len_q - 3'd1) begin
                  clk_enable <= 1'b0;
                  state      <= ST_HOLD;
               end else begin
                  idx        <= idx + 3'd1;
                  byte_start <= 1'b1;
                  byte_tx    <= rw_q ? byte_of(wdata_q, idx[1:0] + 2'd1) : 8'h00;
               end
            end
            ST_HOLD: begin
               ncs_o   <= 1'b1;
               done0   <= !last;
               done1   <= last;
               gap_cnt <= GW'(NCS_GAP - 1);
               state   <= ST_GAP;
            end
            ST_GAP: begin
               gnt0 <= 1'b0;
               gnt1 <= 1'b0;
               if (gap_cnt == '0) state   <= ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
